// File: rtl/lfsr_pkg.sv
// Shared constants and single-step function for the 32-bit Fibonacci LFSR
// (x^32 + x^22 + x^2 + x + 1).
package lfsr_pkg;

    localparam int          LFSR_WIDTH        = 32;
    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    // Feedback is the XOR of the tapped bits and enters at bit 0.
    // A nonzero state always maps to a nonzero state.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational chain of STEPS single LFSR steps.
module lfsr_step_n
    import lfsr_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic [LFSR_WIDTH-1:0] state_i,
    output logic [LFSR_WIDTH-1:0] state_o
);

    logic [LFSR_WIDTH-1:0] chain [0:STEPS];

    assign chain[0] = state_i;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        assign chain[g+1] = lfsr_step(chain[g]);
    end

    assign state_o = chain[STEPS];

endmodule

// File: rtl/lfsr_prng.sv
// Free-running 32-bit LFSR PRNG: auto-seeds on the first edge after reset,
// supports runtime reseed, and advances STEPS bit-shifts per enabled clock.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = LFSR_WIDTH,
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             reseed,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             seeded
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             seeded_q, seeded_d;
    logic [WIDTH-1:0] seed_ld;
    logic [WIDTH-1:0] stepped;

    // A zero seed would lock the register at zero forever, so substitute.
    assign seed_ld = (seed == '0) ? DEFAULT_SEED : seed;

    lfsr_step_n #(
        .STEPS(STEPS)
    ) u_step (
        .state_i(state_q),
        .state_o(stepped)
    );

    always_comb begin
        state_d  = state_q;
        seeded_d = seeded_q;
        if (!seeded_q || reseed) begin
            state_d  = seed_ld;
            seeded_d = 1'b1;
        end else if (en) begin
            state_d = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DEFAULT_SEED;
            seeded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seeded_q <= seeded_d;
        end
    end

    assign lfsr_out = state_q;
    assign seeded   = seeded_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng, run side by side in STEPS=1 and STEPS=8 builds.
module tb_lfsr_prng;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed;
    logic        en;
    logic        reseed;
    logic [31:0] out1, out8;
    logic        seeded1, seeded8;

    int nchk  = 0;
    int nfail = 0;

    // Reference model state (shared seeded flag, per-build state).
    logic [31:0] m_s1, m_s8;
    logic        m_seeded;
    logic [32:0] q1[$];
    logic [32:0] q8[$];

    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(32), .STEPS(1), .DEFAULT_SEED(32'h1)) dut1 (
        .clk(clk), .rst(rst), .seed(seed), .en(en), .reseed(reseed),
        .lfsr_out(out1), .seeded(seeded1)
    );

    lfsr_prng #(.WIDTH(32), .STEPS(8), .DEFAULT_SEED(32'h1)) dut8 (
        .clk(clk), .rst(rst), .seed(seed), .en(en), .reseed(reseed),
        .lfsr_out(out8), .seeded(seeded8)
    );

    function automatic logic [31:0] mstep(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic logic [31:0] mstepn(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = mstep(t);
        return t;
    endfunction

    // Drive one cycle of stimulus, push the model's post-edge expectation,
    // then advance past the edge.
    task automatic drive(input logic [31:0] sd, input logic e, input logic rs);
        logic [31:0] ld;
        seed   = sd;
        en     = e;
        reseed = rs;
        ld = (sd == 32'h0) ? 32'h1 : sd;
        if (!m_seeded || rs) begin
            m_s1 = ld;
            m_s8 = ld;
            m_seeded = 1'b1;
        end else if (e) begin
            m_s1 = mstepn(m_s1, 1);
            m_s8 = mstepn(m_s8, 8);
        end
        q1.push_back({m_seeded, m_s1});
        q8.push_back({m_seeded, m_s8});
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        m_s1 = 32'h1;
        m_s8 = 32'h1;
        m_seeded = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        seed = 32'h0; en = 1'b0; reseed = 1'b0;
        apply_reset();
        @(posedge clk); #1;
        nchk++;
        if (out1 !== 32'h1 || seeded1 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_s1: got out=%h seeded=%b want out=00000001 seeded=0", out1, seeded1);
        end
        nchk++;
        if (out8 !== 32'h1 || seeded8 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_s8: got out=%h seeded=%b want out=00000001 seeded=0", out8, seeded8);
        end
        rst = 1'b1;
    endtask

    task automatic test_autoseed();
        logic [32:0] e1, e8;
        drive(32'hABCDE123, 1'b1, 1'b0);
        e1 = q1.pop_front(); e8 = q8.pop_front();
        nchk++;
        if ({seeded1, out1} !== e1 || out1 !== 32'hABCDE123) begin
            nfail++;
            $display("FAIL autoseed_load: got %b/%h want %b/%h", seeded1, out1, e1[32], e1[31:0]);
        end
        nchk++;
        if ({seeded8, out8} !== e8) begin
            nfail++;
            $display("FAIL autoseed_load_s8: got %b/%h want %b/%h", seeded8, out8, e8[32], e8[31:0]);
        end
        drive(32'h1234_5678, 1'b1, 1'b0);
        e1 = q1.pop_front(); e8 = q8.pop_front();
        nchk++;
        if ({seeded1, out1} !== e1 || out1 !== 32'h579BC247) begin
            nfail++;
            $display("FAIL autoseed_step: got %h want %h (579bc247)", out1, e1[31:0]);
        end
        nchk++;
        if ({seeded8, out8} !== e8) begin
            nfail++;
            $display("FAIL autoseed_step_s8: got %h want %h", out8, e8[31:0]);
        end
    endtask

    task automatic test_zero_seed();
        logic [32:0] e1;
        apply_reset();
        #2 rst = 1'b1;
        drive(32'h0, 1'b1, 1'b0);
        e1 = q1.pop_front(); void'(q8.pop_front());
        nchk++;
        if ({seeded1, out1} !== e1 || out1 !== 32'h1) begin
            nfail++;
            $display("FAIL zero_seed_load: got %h want %h", out1, e1[31:0]);
        end
        drive(32'h0, 1'b1, 1'b0);
        e1 = q1.pop_front(); void'(q8.pop_front());
        nchk++;
        if (out1 !== e1[31:0] || out1 !== 32'h3) begin
            nfail++;
            $display("FAIL zero_seed_step: got %h want 00000003", out1);
        end
    endtask

    task automatic test_hold_enable();
        logic [32:0] e1, e8;
        logic [31:0] held;
        held = out1;
        for (int i = 0; i < 5; i++) begin
            drive($urandom, 1'b0, 1'b0);
            e1 = q1.pop_front(); e8 = q8.pop_front();
            nchk++;
            if (out1 !== e1[31:0] || out1 !== held || out8 !== e8[31:0]) begin
                nfail++;
                $display("FAIL hold[%0d]: got %h/%h want %h/%h", i, out1, out8, e1[31:0], e8[31:0]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            held = out1;
            drive($urandom, 1'b1, 1'b0);
            e1 = q1.pop_front(); e8 = q8.pop_front();
            nchk++;
            if (out1 !== e1[31:0] || out1 === held) begin
                nfail++;
                $display("FAIL enable_s1[%0d]: got %h want %h", i, out1, e1[31:0]);
            end
            nchk++;
            if (out8 !== e8[31:0]) begin
                nfail++;
                $display("FAIL enable_s8[%0d]: got %h want %h", i, out8, e8[31:0]);
            end
        end
    endtask

    task automatic test_reseed();
        logic [32:0] e1, e8;
        drive(32'hABCDE123, 1'b1, 1'b1);
        e1 = q1.pop_front(); e8 = q8.pop_front();
        nchk++;
        if (out1 !== e1[31:0] || out1 !== 32'hABCDE123 || out8 !== 32'hABCDE123) begin
            nfail++;
            $display("FAIL reseed_load: got %h/%h want abcde123", out1, out8);
        end
        drive(32'h0BAD_F00D, 1'b1, 1'b0);
        e1 = q1.pop_front(); e8 = q8.pop_front();
        nchk++;
        if (out1 !== e1[31:0] || out1 !== 32'h579BC247) begin
            nfail++;
            $display("FAIL reseed_step: got %h want 579bc247", out1);
        end
        nchk++;
        if (out8 !== e8[31:0]) begin
            nfail++;
            $display("FAIL reseed_step_s8: got %h want %h", out8, e8[31:0]);
        end
        drive(32'h0, 1'b0, 1'b1);
        e1 = q1.pop_front(); void'(q8.pop_front());
        nchk++;
        if (out1 !== e1[31:0] || out1 !== 32'h1) begin
            nfail++;
            $display("FAIL reseed_zero: got %h want 00000001", out1);
        end
    endtask

    task automatic test_async_reset();
        logic [32:0] e1;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, 1'b1, 1'b0);
            void'(q1.pop_front()); void'(q8.pop_front());
        end
        #2;
        apply_reset();
        nchk++;
        if (out1 !== 32'h1 || seeded1 !== 1'b0 || out8 !== 32'h1 || seeded8 !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset: got %h/%b %h/%b want 00000001/0", out1, seeded1, out8, seeded8);
        end
        #1 rst = 1'b1;
        drive(32'hCAFE_0001, 1'b0, 1'b0);
        e1 = q1.pop_front(); void'(q8.pop_front());
        nchk++;
        if ({seeded1, out1} !== e1 || out1 !== 32'hCAFE0001) begin
            nfail++;
            $display("FAIL reseed_after_reset: got %b/%h want 1/cafe0001", seeded1, out1);
        end
    endtask

    task automatic test_long_run();
        logic [32:0] e1, e8;
        int bad;
        bad = 0;
        drive(32'hABCDE123, 1'b1, 1'b1);
        void'(q1.pop_front()); void'(q8.pop_front());
        for (int i = 0; i < 20000; i++) begin
            drive($urandom, 1'b1, 1'b0);
            e1 = q1.pop_front(); e8 = q8.pop_front();
            nchk++;
            if (out1 === 32'h0 || out1 !== e1[31:0] || out8 !== e8[31:0]) begin
                nfail++;
                bad++;
                if (bad < 5)
                    $display("FAIL long_run[%0d]: got %h/%h want %h/%h", i, out1, out8, e1[31:0], e8[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_autoseed();
        test_zero_seed();
        test_hold_enable();
        test_reseed();
        test_async_reset();
        test_long_run();
        nchk++;
        if (q1.size() != 0 || q8.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0", q1.size(), q8.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
